// File: rtl/stack_ram_arbiter_if.sv
// Requester-side bundle of the stack RAM arbiter: request handshake plus
// the routed read-response channel.
interface stack_ram_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int AW      = 32
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    req_wr;
   logic [NUM_REQ*AW-1:0] req_addr;
   logic [NUM_REQ*32-1:0] req_wdata;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic                  rsp_err;
   logic [31:0]           rsp_rdata;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/stack_ram_arbiter.sv
// Round-robin arbiter sharing the single-port toggle-enable stack BRAM
// between NUM_REQ requesters, with range checking and response routing.
module stack_ram_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DEPTH   = 2,
   parameter int AW      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   stack_ram_arbiter_if.slave    bus,
   output logic                  u_en,
   output logic                  wr_en,
   output logic [AW-1:0]         addr,
   output logic [31:0]           d_in,
   input  logic [31:0]           d_out
);
   localparam int DATA_W = 32;
   localparam int IW     = $clog2(NUM_REQ);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t              state_p0, state_nxt;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       gnt_idx;
   logic [NUM_REQ-1:0]  grant;
   logic                found;
   int                  j;
   logic                accept;
   logic [AW-1:0]       sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                sel_wr;
   logic                sel_in_range;
   logic [IW-1:0]       pend_idx_p0;
   logic                pend_wr_p0;
   logic                pend_err_p0;
   logic [NUM_REQ-1:0]  rsp_valid_nxt;
   logic                rsp_err_nxt;
   logic [DATA_W-1:0]   rsp_rdata_nxt;

   // Search upward from the pointer, wrapping; first valid requester wins.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && bus.req_valid[j]) begin
            found      = 1'b1;
            grant[j]   = 1'b1;
            gnt_idx    = IW'(j);
         end
      end
   end

   assign bus.req_ready = reset ? '0 : grant;
   assign accept        = |(bus.req_valid & bus.req_ready);
   assign sel_addr      = bus.req_addr[int'(gnt_idx)*AW +: AW];
   assign sel_wdata     = bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
   assign sel_wr        = bus.req_wr[gnt_idx];
   assign sel_in_range  = sel_addr < AW'(DEPTH);

   // ---- stage p0: pending response record ----
   always_ff @(posedge clk) begin
      if (reset) state_p0 <= IDLE;
      else       state_p0 <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      case (state_p0)
         IDLE:    state_nxt = accept ? ACTIVE : IDLE;
         ACTIVE:  state_nxt = accept ? ACTIVE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rsp_valid_nxt = '0;
      rsp_err_nxt   = 1'b0;
      rsp_rdata_nxt = '0;
      if (state_p0 == ACTIVE) begin
         rsp_valid_nxt[pend_idx_p0] = 1'b1;
         rsp_err_nxt                = pend_err_p0;
         if (!pend_err_p0 && !pend_wr_p0) rsp_rdata_nxt = d_out;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         pend_idx_p0 <= gnt_idx;
         pend_wr_p0  <= sel_wr;
         pend_err_p0 <= !sel_in_range;
      end
   end

   // Kept out of reset: en inside the BRAM is not reset, so touching u_en
   // here would launch a phantom access. Powers up at 0 with the device.
   always_ff @(posedge clk) begin
      if (accept && sel_in_range) u_en <= ~u_en;
   end

   // ---- stage p1: BRAM command and registered response ----
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr        <= '0;
         wr_en         <= 1'b0;
         addr          <= '0;
         d_in          <= '0;
         bus.rsp_valid <= '0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
      end else begin
         bus.rsp_valid <= rsp_valid_nxt;
         bus.rsp_err   <= rsp_err_nxt;
         bus.rsp_rdata <= rsp_rdata_nxt;
         if (accept) begin
            rr_ptr <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            if (sel_in_range) begin
               addr  <= sel_addr;
               wr_en <= sel_wr;
               d_in  <= sel_wdata;
            end
         end
      end
   end
endmodule

// File: tb/tb_stack_ram_arbiter.sv
// Directed bench for stack_ram_arbiter with a toggle-enable BRAM model and
// a scoreboard of expected responses.
module tb_stack_ram_arbiter;
   localparam int NUM_REQ = 2;
   localparam int DEPTH   = 2;
   localparam int AW      = 32;

   typedef struct {
      int          idx;
      bit          err;
      logic [31:0] rdata;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        u_en, wr_en;
   logic [AW-1:0] addr;
   logic [31:0] d_in;
   logic [31:0] d_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t sb[$];
   exp_t m;

   logic        u_exp = 1'b0;
   logic        wr_exp = 1'b0;
   logic [31:0] addr_exp = '0;
   logic [31:0] d_exp = '0;
   logic [31:0] ref_mem [DEPTH];

   bit          en_m = 1'b0;
   logic [31:0] mem_m [DEPTH];

   stack_ram_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW)) bus ();

   stack_ram_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .u_en  (u_en),
      .wr_en (wr_en),
      .addr  (addr),
      .d_in  (d_in),
      .d_out (d_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Toggle-enable BRAM: access on the falling edge when u_en differs from en.
   always @(negedge clk) begin
      if (u_en != en_m) begin
         en_m <= u_en;
         if (wr_en) mem_m[addr[0]] <= d_in;
         else       d_out <= mem_m[addr[0]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
         logic [1:0] oh;
         m = sb.pop_front();
         oh = 2'b01 << m.idx;
         chk("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
         chk("rsp_err",   64'(bus.rsp_err),   64'(m.err));
         chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(m.rdata));
      end else begin
         chk("rsp_idle", 64'(bus.rsp_valid), 64'd0);
      end
   end

   task automatic set_req(input int r, input bit v, input bit wr,
                          input logic [31:0] a, input logic [31:0] d);
      bus.req_valid[r]          = v;
      bus.req_wr[r]             = wr;
      bus.req_addr[r*AW +: AW]  = a;
      bus.req_wdata[r*32 +: 32] = d;
   endtask

   task automatic tick(input logic [1:0] exp_rdy);
      exp_t e;
      int g;
      logic [31:0] a, wd;
      bit wr;
      @(negedge clk);
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      if ((bus.req_valid & exp_rdy) != 0) begin
         g  = exp_rdy[1] ? 1 : 0;
         a  = bus.req_addr[g*AW +: AW];
         wd = bus.req_wdata[g*32 +: 32];
         wr = bus.req_wr[g];
         e.idx = g;
         e.err = (a >= DEPTH);
         e.rdata = '0;
         e.due = cyc + 2;
         if (!e.err) begin
            u_exp = ~u_exp;
            addr_exp = a;
            wr_exp = wr;
            d_exp = wd;
            if (wr) ref_mem[a[0]] = wd;
            else    e.rdata = ref_mem[a[0]];
         end
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      chk("u_en",  64'(u_en),  64'(u_exp));
      chk("wr_en", 64'(wr_en), 64'(wr_exp));
      chk("addr",  64'(addr),  64'(addr_exp));
      chk("d_in",  64'(d_in),  64'(d_exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i] = '0;
         mem_m[i] = '0;
      end
      d_out = '0;
      reset = 1'b1;
      bus.req_valid = '0;
      bus.req_wr = '0;
      bus.req_addr = '0;
      bus.req_wdata = '0;

      // Reset state
      tick(2'b00);
      chk("rsp_err_rst",   64'(bus.rsp_err),   64'd0);
      chk("rsp_rdata_rst", 64'(bus.rsp_rdata), 64'd0);
      tick(2'b00);
      tick(2'b00);
      reset = 1'b0;

      // Write then read, requester 0
      set_req(0, 1'b1, 1'b1, 32'd1, 32'h6);
      tick(2'b01);
      set_req(0, 1'b1, 1'b0, 32'd1, 32'h0);
      tick(2'b01);
      set_req(0, 1'b0, 1'b0, 32'd0, 32'h0);
      tick(2'b00);

      // Out of range from requester 1, then an in-range read
      set_req(1, 1'b1, 1'b0, 32'd2, 32'h0);
      tick(2'b10);
      set_req(1, 1'b1, 1'b0, 32'd1, 32'h0);
      tick(2'b10);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'h0);
      tick(2'b00);

      // Contention, pointer back at 0
      set_req(0, 1'b1, 1'b0, 32'd1, 32'h0);
      set_req(1, 1'b1, 1'b1, 32'd0, 32'h55);
      tick(2'b01);
      tick(2'b10);
      tick(2'b01);
      tick(2'b10);
      set_req(0, 1'b0, 1'b0, 32'd0, 32'h0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'h0);
      tick(2'b00);

      // Back-to-back streaming
      set_req(0, 1'b1, 1'b1, 32'd0, 32'h3);
      tick(2'b01);
      set_req(0, 1'b1, 1'b1, 32'd1, 32'h6);
      tick(2'b01);
      set_req(0, 1'b1, 1'b0, 32'd0, 32'h0);
      tick(2'b01);
      set_req(0, 1'b1, 1'b0, 32'd1, 32'h0);
      tick(2'b01);
      set_req(0, 1'b0, 1'b0, 32'd0, 32'h0);
      tick(2'b00);

      // Reset right after a read accept
      set_req(0, 1'b1, 1'b0, 32'd0, 32'h0);
      tick(2'b01);
      reset = 1'b1;
      set_req(1, 1'b1, 1'b0, 32'd1, 32'h0);
      sb.delete();
      addr_exp = '0;
      wr_exp = 1'b0;
      d_exp = '0;
      tick(2'b00);
      tick(2'b00);
      reset = 1'b0;
      tick(2'b01);
      tick(2'b10);
      set_req(0, 1'b0, 1'b0, 32'd0, 32'h0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'h0);

      // Idle
      for (int i = 0; i < 10; i++) tick(2'b00);
      tick(2'b00);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
